// File: rtl/i2s_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pixel_packer
// Description : Packs an RGB888 pixel stream into 96-bit words of four pixels
//               and buffers them for a downstream I2S video serializer.
//               Frames are delimited by pix_sop/pix_eop; a short final word is
//               completed with PAD_PIXEL. Pixels outside a frame (or a partial
//               word abandoned by a new sop) are counted in overflow_cnt.
// Ports       : pclk, reset            - clock, synchronous active-high reset
//               pix_data/valid/sop/eop - pixel input stream
//               pix_ready              - pixel accepted when valid && ready
//               cts                    - downstream clear-to-send
//               disp_data, datavalid   - head word of the output buffer
//               v_sync                 - head word is the first of a frame
//               overflow_cnt           - saturating dropped-pixel counter
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pixel_packer #(
    parameter logic [23:0] PAD_PIXEL  = 24'h000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sop,
    input  logic        pix_eop,
    output logic        pix_ready,
    input  logic        cts,
    output logic [95:0] disp_data,
    output logic        datavalid,
    output logic        v_sync,
    output logic [15:0] overflow_cnt
);

    localparam int              c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH = FIFO_DEPTH[c_AW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Packer state. Only lanes 0..2 are held; lane 3 goes straight into the push.
    state_t         r_state_q, w_state_d;
    logic [1:0]     r_lane_q,  w_lane_d;
    logic [71:0]    r_word_q,  w_word_d;
    logic           r_sof_q,   w_sof_d;
    logic [15:0]    r_ovf_q,   w_ovf_d;

    // Output buffer: {sof, word} per entry
    logic [96:0]    r_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_AW:0]  r_count_q,  w_count_d;

    logic           w_full;
    logic           w_datavalid;
    logic           w_pop;
    logic           w_space;
    logic           w_ready;
    logic           w_accept;
    logic           w_push;
    logic [96:0]    w_push_data;
    logic [96:0]    w_head;
    logic [95:0]    w_flush_word;
    logic [2:0]     w_drop_n;
    logic [16:0]    w_ovf_sum;

    assign w_full      = (r_count_q == c_DEPTH);
    assign w_datavalid = (r_count_q != '0) && !reset;
    assign w_pop       = w_datavalid && cts;
    assign w_head      = r_mem_q[r_rd_ptr_q];
    // A pop in the same cycle frees the slot the push is about to use.
    assign w_space     = !w_full || w_pop;

    always_comb begin
        w_ready = 1'b0;
        if (!reset) begin
            case (r_state_q)
                S_IDLE:  w_ready = 1'b1;
                S_PACK:  w_ready = w_space;
                default: w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = pix_valid && w_ready;

    // Held lanes below r_lane_q are real pixels; the rest become padding.
    always_comb begin
        w_flush_word[23:0] = PAD_PIXEL;
        for (int i = 0; i < 3; i++) begin
            w_flush_word[95-24*i -: 24] = (2'(i) < r_lane_q) ? r_word_q[71-24*i -: 24]
                                                             : PAD_PIXEL;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_lane_d    = r_lane_q;
        w_word_d    = r_word_q;
        w_sof_d     = r_sof_q;
        w_drop_n    = 3'd0;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (pix_sop) begin
                        w_word_d[71:48] = pix_data;
                        w_lane_d        = 2'd1;
                        w_sof_d         = 1'b1;
                        w_state_d       = pix_eop ? S_FLUSH : S_PACK;
                    end else begin
                        w_drop_n = 3'd1;
                    end
                end
            end
            S_PACK: begin
                if (w_accept) begin
                    if (pix_sop) begin
                        // Restart: the lanes already held are abandoned.
                        w_drop_n        = {1'b0, r_lane_q};
                        w_word_d[71:48] = pix_data;
                        w_lane_d        = 2'd1;
                        w_sof_d         = 1'b1;
                        w_state_d       = pix_eop ? S_FLUSH : S_PACK;
                    end else if (r_lane_q == 2'd3) begin
                        w_push      = 1'b1;
                        w_push_data = {r_sof_q, r_word_q, pix_data};
                        w_lane_d    = 2'd0;
                        w_sof_d     = 1'b0;
                        if (pix_eop) begin
                            w_state_d = S_IDLE;
                        end
                    end else begin
                        case (r_lane_q)
                            2'd0:    w_word_d[71:48] = pix_data;
                            2'd1:    w_word_d[47:24] = pix_data;
                            default: w_word_d[23:0]  = pix_data;
                        endcase
                        w_lane_d = r_lane_q + 2'd1;
                        if (pix_eop) begin
                            w_state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (w_space) begin
                    w_push      = 1'b1;
                    w_push_data = {r_sof_q, w_flush_word};
                    w_lane_d    = 2'd0;
                    w_sof_d     = 1'b0;
                    w_state_d   = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    assign w_ovf_sum = {1'b0, r_ovf_q} + {14'd0, w_drop_n};
    assign w_ovf_d   = w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];

    always_comb begin
        w_wr_ptr_d = w_push ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_lane_q   <= 2'd0;
            r_word_q   <= '0;
            r_sof_q    <= 1'b0;
            r_ovf_q    <= 16'd0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_lane_q   <= w_lane_d;
            r_word_q   <= w_word_d;
            r_sof_q    <= w_sof_d;
            r_ovf_q    <= w_ovf_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: an empty buffer is never shown on disp_data.
    always_ff @(posedge pclk) begin
        if (w_push && !reset) begin
            r_mem_q[r_wr_ptr_q] <= w_push_data;
        end
    end

    assign pix_ready    = w_ready;
    assign datavalid    = w_datavalid;
    assign disp_data    = w_datavalid ? w_head[95:0] : 96'h0;
    assign v_sync       = w_datavalid && w_head[96];
    assign overflow_cnt = r_ovf_q;

endmodule
`default_nettype wire
